// File: rtl/instr_buffer_if.sv
// rtl/instr_buffer_if.sv - fetch-line and decode handshake bundle for instr_buffer
// Ports grouped here:
//   admin2ib_* : one fetch line per cycle (up to 4 lanes) from fetch admin logic
//   ib2admin_ready : buffer has room for a full 4-lane line
//   ib2dec_*   : show-ahead head entry with valid/ready handshake to decode
//   ib_count   : occupied entries
// Modports: slave = the buffer, master = surrounding fetch/decode environment.
interface instr_buffer_if #(
    parameter int DEPTH = 16
);
    localparam int PTR_W = $clog2(DEPTH);

    logic                admin2ib_wr_en;
    logic [63:0]         admin2ib_pc;
    logic [127:0]        admin2ib_instr;
    logic [3:0]          admin2ib_instr_valid;
    logic [3:0]          admin2ib_predicttaken;
    logic [127:0]        admin2ib_predicttarget;
    logic                ib2admin_ready;
    logic                ib2dec_valid;
    logic                ib2dec_ready;
    logic [31:0]         ib2dec_instr;
    logic [63:0]         ib2dec_pc;
    logic                ib2dec_predicttaken;
    logic [31:0]         ib2dec_predicttarget;
    logic [PTR_W:0]      ib_count;

    modport slave (
        input  admin2ib_wr_en, admin2ib_pc, admin2ib_instr, admin2ib_instr_valid,
        input  admin2ib_predicttaken, admin2ib_predicttarget, ib2dec_ready,
        output ib2admin_ready, ib2dec_valid, ib2dec_instr, ib2dec_pc,
        output ib2dec_predicttaken, ib2dec_predicttarget, ib_count
    );

    modport master (
        output admin2ib_wr_en, admin2ib_pc, admin2ib_instr, admin2ib_instr_valid,
        output admin2ib_predicttaken, admin2ib_predicttarget, ib2dec_ready,
        input  ib2admin_ready, ib2dec_valid, ib2dec_instr, ib2dec_pc,
        input  ib2dec_predicttaken, ib2dec_predicttarget, ib_count
    );
endinterface

// File: rtl/instr_buffer.sv
// rtl/instr_buffer.sv - circular instruction FIFO between fetch admin and decode
// Ports:
//   clock, reset_n (async assert, active-low), flush (redirect, discards all content)
//   ib : instr_buffer_if.slave carrying the fetch line, decode handshake and ib_count
// Optional feature macro IB_BYPASS_EN: when the buffer is empty, lane 0 of an
// accepted line is presented to decode in the same cycle.
module instr_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    instr_buffer_if.slave   ib
);

    logic [31:0] instr_mem [DEPTH];
    logic [63:0] pc_mem    [DEPTH];
    logic        taken_mem [DEPTH];
    logic [31:0] tgt_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [2:0]       n_lanes;
    logic             enq, byp, skip, rd_adv, deq, ready;
    logic [2:0]       wr_cnt;
    logic [3:0]       lane_en;
    logic [PTR_W-1:0] lane_addr [4];

    always_comb begin
        // Only the leading run of valid lanes counts; anything after the first hole is ignored.
        casez (ib.admin2ib_instr_valid)
            4'b???0: n_lanes = 3'd0;
            4'b??01: n_lanes = 3'd1;
            4'b?011: n_lanes = 3'd2;
            4'b0111: n_lanes = 3'd3;
            default: n_lanes = 3'd4;
        endcase

        ready = (count_q <= (PTR_W+1)'(DEPTH - 4));
        enq   = ib.admin2ib_wr_en & ready & ~flush;
`ifdef IB_BYPASS_EN
        byp   = enq & (count_q == '0) & (n_lanes != 3'd0);
`else
        byp   = 1'b0;
`endif
        ib.ib2dec_valid = ((count_q != '0) & ~flush) | byp;
        deq    = ib.ib2dec_valid & ib.ib2dec_ready;
        // A bypassed lane 0 taken by decode is never written into storage.
        skip   = byp & ib.ib2dec_ready;
        rd_adv = deq & ~byp;
        wr_cnt = enq ? (n_lanes - {2'b00, skip}) : 3'd0;

        for (int k = 0; k < 4; k++) begin
            lane_en[k]   = enq && (3'(k) >= {2'b00, skip}) && (3'(k) < n_lanes);
            lane_addr[k] = wr_ptr_q + PTR_W'(k) - PTR_W'(skip);
        end

        ib.ib2dec_instr         = '0;
        ib.ib2dec_pc            = '0;
        ib.ib2dec_predicttaken  = 1'b0;
        ib.ib2dec_predicttarget = '0;
        if (byp) begin
            ib.ib2dec_instr         = ib.admin2ib_instr[31:0];
            ib.ib2dec_pc            = ib.admin2ib_pc;
            ib.ib2dec_predicttaken  = ib.admin2ib_predicttaken[0];
            ib.ib2dec_predicttarget = ib.admin2ib_predicttarget[31:0];
        end else if (ib.ib2dec_valid) begin
            ib.ib2dec_instr         = instr_mem[rd_ptr_q];
            ib.ib2dec_pc            = pc_mem[rd_ptr_q];
            ib.ib2dec_predicttaken  = taken_mem[rd_ptr_q];
            ib.ib2dec_predicttarget = tgt_mem[rd_ptr_q];
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(wr_cnt);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_adv);
        count_d  = count_q + (PTR_W+1)'(wr_cnt) - (PTR_W+1)'(rd_adv);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        ib.ib2admin_ready = ready;
        ib.ib_count       = count_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clock) begin
        for (int k = 0; k < 4; k++) begin
            if (lane_en[k]) begin
                instr_mem[lane_addr[k]] <= ib.admin2ib_instr[32*k +: 32];
                pc_mem[lane_addr[k]]    <= ib.admin2ib_pc + 64'(4 * k);
                taken_mem[lane_addr[k]] <= ib.admin2ib_predicttaken[k];
                tgt_mem[lane_addr[k]]   <= ib.admin2ib_predicttarget[32*k +: 32];
            end
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
// tb/tb_instr_buffer.sv - directed self-checking bench for instr_buffer
module tb_instr_buffer;
    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic reset_n;
    logic flush;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    instr_buffer_if #(.DEPTH(DEPTH)) ib ();

    instr_buffer #(.DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .ib      (ib)
    );

    function automatic logic [31:0] fi(input logic [63:0] p);
        return p[31:0] ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] ft(input logic [63:0] p);
        return p[31:0] - 32'h0000_1004;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ib.admin2ib_wr_en         = 1'b0;
        ib.admin2ib_pc            = '0;
        ib.admin2ib_instr         = '0;
        ib.admin2ib_instr_valid   = '0;
        ib.admin2ib_predicttaken  = '0;
        ib.admin2ib_predicttarget = '0;
    endtask

    task automatic put(input logic [63:0] pc, input logic [3:0] v, input logic [3:0] tk);
        logic [63:0] lp;
        ib.admin2ib_wr_en        = 1'b1;
        ib.admin2ib_pc           = pc;
        ib.admin2ib_instr_valid  = v;
        ib.admin2ib_predicttaken = tk;
        for (int k = 0; k < 4; k++) begin
            lp = pc + 64'(4 * k);
            ib.admin2ib_instr[32*k +: 32]         = fi(lp);
            ib.admin2ib_predicttarget[32*k +: 32] = ft(lp);
        end
    endtask

    task automatic head(input string tag, input logic [63:0] pc, input logic tk);
        chk({tag, "_valid"},  64'(ib.ib2dec_valid), 64'd1);
        chk({tag, "_pc"},     ib.ib2dec_pc, pc);
        chk({tag, "_instr"},  64'(ib.ib2dec_instr), 64'(fi(pc)));
        chk({tag, "_taken"},  64'(ib.ib2dec_predicttaken), 64'(tk));
        chk({tag, "_target"}, 64'(ib.ib2dec_predicttarget), 64'(ft(pc)));
    endtask

    initial begin
        logic [63:0] exp_pc [5];
        reset_n = 1'b0;
        flush   = 1'b0;
        ib.ib2dec_ready = 1'b0;
        idle();
        cyc();
        cyc();
        chk("rst_valid", 64'(ib.ib2dec_valid), 64'd0);
        chk("rst_count", 64'(ib.ib_count), 64'd0);
        chk("rst_ready", 64'(ib.ib2admin_ready), 64'd1);
        chk("rst_pc", ib.ib2dec_pc, 64'd0);
        chk("rst_instr", 64'(ib.ib2dec_instr), 64'd0);
        reset_n = 1'b1;
        cyc();

        // Full line streamed straight through to decode.
        put(64'h1000, 4'b1111, 4'b0000);
        ib.ib2dec_ready = 1'b1;
        #1;
        chk("t1_pre_valid", 64'(ib.ib2dec_valid), 64'd0);
        cyc();
        idle();
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_count%0d", i), 64'(ib.ib_count), 64'(4 - i));
            head($sformatf("t1_e%0d", i), 64'h1000 + 64'(4 * i), 1'b0);
            cyc();
        end
        chk("t1_end_count", 64'(ib.ib_count), 64'd0);
        chk("t1_end_valid", 64'(ib.ib2dec_valid), 64'd0);

        // Two-lane line with a prediction on lane 1.
        ib.ib2dec_ready = 1'b0;
        put(64'h3000, 4'b0011, 4'b0010);
        cyc();
        idle();
        #1;
        chk("t2_count", 64'(ib.ib_count), 64'd2);
        head("t2_e0", 64'h3000, 1'b0);
        ib.ib2dec_ready = 1'b1;
        cyc();
        chk("t2_count1", 64'(ib.ib_count), 64'd1);
        head("t2_e1", 64'h3004, 1'b1);
        chk("t2_target", 64'(ib.ib2dec_predicttarget), 64'h2000);
        cyc();
        chk("t2_end_count", 64'(ib.ib_count), 64'd0);

        // Fill to DEPTH with decode stalled; extra lines must be ignored.
        ib.ib2dec_ready = 1'b0;
        for (int l = 0; l < 4; l++) begin
            put(64'h4000 + 64'(16 * l), 4'b1111, 4'b0000);
            #1;
            chk($sformatf("t3_ready_l%0d", l), 64'(ib.ib2admin_ready), 64'd1);
            cyc();
            chk($sformatf("t3_count_l%0d", l), 64'(ib.ib_count), 64'(4 * (l + 1)));
        end
        chk("t3_full_ready", 64'(ib.ib2admin_ready), 64'd0);
        put(64'h9000, 4'b1111, 4'b0000);
        cyc();
        cyc();
        chk("t3_full_hold", 64'(ib.ib_count), 64'd16);
        idle();
        ib.ib2dec_ready = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3_dcount%0d", i), 64'(ib.ib_count), 64'(16 - i));
            chk($sformatf("t3_dready%0d", i), 64'(ib.ib2admin_ready), 64'((16 - i) <= 12));
            head($sformatf("t3_e%0d", i), 64'h4000 + 64'(16 * (i / 4)) + 64'(4 * (i % 4)), 1'b0);
            cyc();
        end
        chk("t3_end_count", 64'(ib.ib_count), 64'd0);

        // Flush at count 9 with a line pending.
        ib.ib2dec_ready = 1'b0;
        put(64'h5000, 4'b1111, 4'b0000);
        cyc();
        put(64'h5010, 4'b1111, 4'b0000);
        cyc();
        put(64'h5020, 4'b0001, 4'b0000);
        cyc();
        chk("t4_count9", 64'(ib.ib_count), 64'd9);
        put(64'h5100, 4'b1111, 4'b0000);
        ib.ib2dec_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("t4_flush_valid", 64'(ib.ib2dec_valid), 64'd0);
        cyc();
        flush = 1'b0;
        idle();
        #1;
        chk("t4_post_count", 64'(ib.ib_count), 64'd0);
        chk("t4_post_valid", 64'(ib.ib2dec_valid), 64'd0);
        ib.ib2dec_ready = 1'b0;
        cyc();
        chk("t4_not_stored", 64'(ib.ib_count), 64'd0);

        // Fill 14, drain 14, then a line that straddles entry 15 -> 0.
        put(64'h6000, 4'b1111, 4'b0000);
        cyc();
        put(64'h6010, 4'b1111, 4'b0000);
        cyc();
        put(64'h6020, 4'b1111, 4'b0000);
        cyc();
        chk("t5_count12", 64'(ib.ib_count), 64'd12);
        put(64'h6030, 4'b0000, 4'b0000);
        cyc();
        chk("t5_nolane_noop", 64'(ib.ib_count), 64'd12);
        put(64'h6030, 4'b1011, 4'b0000);
        cyc();
        chk("t5_hole_count14", 64'(ib.ib_count), 64'd14);
        idle();
        ib.ib2dec_ready = 1'b1;
        #1;
        for (int i = 0; i < 14; i++) begin
            head($sformatf("t5_e%0d", i), 64'h6000 + 64'(16 * (i / 4)) + 64'(4 * (i % 4)), 1'b0);
            cyc();
        end
        chk("t5_drained", 64'(ib.ib_count), 64'd0);
        put(64'h7000, 4'b1111, 4'b0000);
        cyc();
        put(64'h8000, 4'b0011, 4'b0000);
        #1;
        chk("t5_wrap_count4", 64'(ib.ib_count), 64'd4);
        head("t5_w0", 64'h7000, 1'b0);
        cyc();
        idle();
        #1;
        chk("t5_enq_deq_count", 64'(ib.ib_count), 64'd5);
        exp_pc[0] = 64'h7004;
        exp_pc[1] = 64'h7008;
        exp_pc[2] = 64'h700C;
        exp_pc[3] = 64'h8000;
        exp_pc[4] = 64'h8004;
        for (int i = 0; i < 5; i++) begin
            head($sformatf("t5_w%0d", i + 1), exp_pc[i], 1'b0);
            cyc();
        end
        chk("t5_wrap_end", 64'(ib.ib_count), 64'd0);

        // Asynchronous reset mid-stream.
        ib.ib2dec_ready = 1'b0;
        put(64'hA000, 4'b1111, 4'b0000);
        cyc();
        idle();
        #1;
        chk("t6_pre_count", 64'(ib.ib_count), 64'd4);
        chk("t6_pre_valid", 64'(ib.ib2dec_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(ib.ib2dec_valid), 64'd0);
        chk("t6_async_count", 64'(ib.ib_count), 64'd0);
        chk("t6_async_ready", 64'(ib.ib2admin_ready), 64'd1);
        chk("t6_async_pc", ib.ib2dec_pc, 64'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("t6_post_count", 64'(ib.ib_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
